f_mult_pipe: RTL and testbench
==============================

Name: f_mult_pipe

Overview:
- Parametrised, fully pipelined floating-point multiplier: next generation of the three-stage FP multiply (calculate, shift, round).
- Generalised to any IEEE-754-style format via EXP_W/MAN_W; implements all five static rounding modes, full special-value handling and IEEE flags.
- Valid/ready handshake on input and output, so it can sit directly behind the FP issue stage and in front of FP writeback.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (hidden bit excluded)
W, 1+EXP_W+MAN_W, derived operand width (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and rounding mode valid
in_ready  out  1  pipeline can accept this cycle
a  in  W  operand A
b  in  W  operand B
rounding  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101/110/111 treated as RNE (DYN is resolved upstream)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  W  product
flags  out  5  packed {NV, DZ, OF, UF, NX}

Behaviour:
- Reset (async, rst_n low): all stage valid bits clear; out_valid=0, y=0, flags=0. Takes effect immediately, including mid-operation; in-flight ops are discarded.
- Latency: 3 cycles. An op accepted at edge N appears with out_valid=1 after edge N+3 if there is no stall. Throughput is 1 op/cycle.
- Handshake:
  - Accept when in_valid & in_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall.
  - During a stall every stage holds its contents; y and flags stay stable while out_valid=1 and out_ready=0.
  - Bubbles propagate as valid=0.
- S1:
  - Classify each operand: zero, subnormal, normal, inf, qNaN, sNaN (sNaN = exp all ones, mantissa≠0, mantissa MSB=0).
  - Subnormal inputs are treated as signed zero (DAZ).
  - Biased exponent sum e = ea + eb − BIAS, with BIAS = 2^(EXP_W−1)−1, computed signed at EXP_W+2 bits.
  - Mantissa product of {hidden,man} × {hidden,man}, 2·(MAN_W+1) bits.
  - Sign = a[W−1]^b[W−1].
- S2:
  - If product MSB=1: shift right 1 and e+1.
  - Extract MAN_W result bits, guard bit, sticky (OR of the remainder).
- S3:
  - Round increment by mode. RNE: G&(S|L). RTZ: 0. RDN: sign&(G|S). RUP: ~sign&(G|S). RMM: G.
  - Mantissa carry-out sets the mantissa to 0 and e+1.
- Overflow: e ≥ 2^EXP_W−1 after rounding. Raises OF|NX. Result by mode:
  - RNE/RMM: ±Inf.
  - RTZ: ±max-finite.
  - RDN: −Inf when negative, +max-finite when positive.
  - RUP: +Inf when positive, −max-finite when negative.
- Underflow: e ≤ 0 after rounding. Result is flushed to signed zero; raises UF|NX.
- Specials override the arithmetic result, in priority order:
  1. Any NaN input → canonical NaN (sign 0, exp all ones, mantissa MSB only); NV if either input is sNaN.
  2. 0×Inf → canonical NaN, NV.
  3. Inf×x → signed Inf, no flags.
  4. Zero×x → signed zero, no flags.
- NX = G|S for finite normal results. DZ is always 0.
- Specials are resolved in S1 and carried down the pipe as a tag.

Decomposition:
- Package fp_pkg holds:
  - rm_e enum (RNE, RTZ, RDN, RUP, RMM).
  - Flag index constants FLAG_NV..FLAG_NX.
  - fp_class_t struct {zero, sub, norm, inf, qnan, snan}.
  - Stage-register structs parametrised by width via localparams in the module.
- One sub-module, f_classify #(EXP_W, MAN_W): combinational operand classifier, instantiated twice in S1.

Test Plan:
1. binary32, RNE, 0x3FC00000×0x40000000 (1.5×2.0) → y=0x40400000, flags=0, out_valid exactly 3 cycles after accept.
2. 0x00000000×0x7F800000 → y=0x7FC00000, NV=1. Then 0x7F800001×0x3F800000 (sNaN) → 0x7FC00000, NV=1.
3. 0x7F7FFFFF×0x40000000 → RNE: 0x7F800000, OF|NX. RTZ: 0x7F7FFFFF, OF|NX. RDN with sign-flipped A: 0xFF800000.
4. 0x3F800001×0x3F800001 → RNE: 0x3F800002 NX; RUP: 0x3F800003 NX; RTZ: 0x3F800002 NX. 0x00800000×0x3F000000 → 0x00000000, UF|NX.
5. Back-to-back stream of 6 ops with out_ready low for 4 cycles after the first result → in_ready=0 during the stall, y/flags stable, all 6 results in order, none duplicated. Repeat with EXP_W=5, MAN_W=10: 0x3E00×0x4000 → 0x4200.
6. rst_n pulled low asynchronously with 3 ops in flight → out_valid=0 before the next edge; after release no stale result emerges; the next op completes normally in 3 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP types: rounding modes, flag bit positions, operand class and special tag.
// No logic; imported by the classifier and the multiplier pipeline.
package fp_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic zero;
    logic sub;
    logic norm;
    logic inf;
    logic qnan;
    logic snan;
  } fp_class_t;

  // Codes 101..111 fall back to round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] code);
    case (code)
      3'b001:  return RTZ;
      3'b010:  return RDN;
      3'b011:  return RUP;
      3'b100:  return RMM;
      default: return RNE;
    endcase
  endfunction

endpackage

// File: rtl/f_classify.sv
// Combinational operand classifier on the exponent/mantissa fields (sign not needed).
// Zero latency; no state, so no backpressure.
module f_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag_i,
  output fp_class_t              cls_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_zero;
  logic             exp_ones;
  logic             man_zero;

  assign exp_f    = mag_i[MAN_W +: EXP_W];
  assign man_f    = mag_i[MAN_W-1:0];
  assign exp_zero = ~|exp_f;
  assign exp_ones = &exp_f;
  assign man_zero = ~|man_f;

  always_comb begin
    cls_o.zero = exp_zero & man_zero;
    cls_o.sub  = exp_zero & ~man_zero;
    cls_o.norm = ~exp_zero & ~exp_ones;
    cls_o.inf  = exp_ones & man_zero;
    cls_o.qnan = exp_ones & man_f[MAN_W-1];
    cls_o.snan = exp_ones & ~man_zero & ~man_f[MAN_W-1];
  end

endmodule

// File: rtl/f_mult_pipe.sv
// Pipelined FP multiply (calculate, shift, round, pack); result 3 edges after accept, 1 op/cycle.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready.
module f_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   rounding,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [4:0]   flags
);

  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EW-1:0] EMAX_E = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EW-1:0] ONE_E  = {{(EW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic           vld;
    logic           sign;
    logic [EW-1:0]  e;
    logic [PW-1:0]  prod;
    rm_e            rm;
    special_e       sp;
    logic           nv;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             sign;
    logic [EW-1:0]    e;
    logic [MAN_W-1:0] man;
    logic             g;
    logic             s;
    rm_e              rm;
    special_e         sp;
    logic             nv;
  } s2_t;

  typedef struct packed {
    logic             vld;
    logic             sign;
    logic [EW-1:0]    e;
    logic [MAN_W-1:0] man;
    logic             nx;
    rm_e              rm;
    special_e         sp;
    logic             nv;
  } s3_t;

  s1_t            s1_d, s1_q;
  s2_t            s2_d, s2_q;
  s3_t            s3_d, s3_q;
  logic           out_vld_q;
  logic [W-1:0]   y_d, y_q;
  logic [4:0]     flags_d, flags_q;
  logic           stall;

  assign stall     = out_vld_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_vld_q;
  assign y         = y_q;
  assign flags     = flags_q;

  fp_class_t cls_a, cls_b;
  logic      a_zero, b_zero, a_nan, b_nan;

  f_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.mag_i(a[W-2:0]), .cls_o(cls_a));
  f_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.mag_i(b[W-2:0]), .cls_o(cls_b));

  // S1: exponent sum, raw mantissa product, special-case tag (subnormals count as zero)
  always_comb begin
    a_zero = cls_a.zero | cls_a.sub;
    b_zero = cls_b.zero | cls_b.sub;
    a_nan  = cls_a.qnan | cls_a.snan;
    b_nan  = cls_b.qnan | cls_b.snan;
    s1_d      = '0;
    s1_d.vld  = in_valid;
    s1_d.sign = a[W-1] ^ b[W-1];
    s1_d.e    = {2'b00, a[W-2:MAN_W]} + {2'b00, b[W-2:MAN_W]} - BIAS_E;
    s1_d.prod = PW'({cls_a.norm, a[MAN_W-1:0]}) * PW'({cls_b.norm, b[MAN_W-1:0]});
    s1_d.rm   = decode_rm(rounding);
    if (a_nan | b_nan) begin
      s1_d.sp = SP_NAN;
      s1_d.nv = cls_a.snan | cls_b.snan;
    end else if ((a_zero & cls_b.inf) | (cls_a.inf & b_zero)) begin
      s1_d.sp = SP_NAN;
      s1_d.nv = 1'b1;
    end else if (cls_a.inf | cls_b.inf) begin
      s1_d.sp = SP_INF;
    end else if (a_zero | b_zero) begin
      s1_d.sp = SP_ZERO;
    end
  end

  logic prod_msb;

  always_comb begin
    prod_msb  = s1_q.prod[PW-1];
    s2_d      = '0;
    s2_d.vld  = s1_q.vld;
    s2_d.sign = s1_q.sign;
    s2_d.rm   = s1_q.rm;
    s2_d.sp   = s1_q.sp;
    s2_d.nv   = s1_q.nv;
    s2_d.e    = s1_q.e + (prod_msb ? ONE_E : '0);
    if (prod_msb) begin
      s2_d.man = s1_q.prod[2*MAN_W -: MAN_W];
      s2_d.g   = s1_q.prod[MAN_W];
      s2_d.s   = |s1_q.prod[MAN_W-1:0];
    end else begin
      s2_d.man = s1_q.prod[2*MAN_W-1 -: MAN_W];
      s2_d.g   = s1_q.prod[MAN_W-1];
      s2_d.s   = |s1_q.prod[MAN_W-2:0];
    end
  end

  logic             rnd_inc;
  logic [MAN_W:0]   man_sum;

  always_comb begin
    rnd_inc = 1'b0;
    case (s2_q.rm)
      RTZ:     rnd_inc = 1'b0;
      RDN:     rnd_inc = s2_q.sign & (s2_q.g | s2_q.s);
      RUP:     rnd_inc = ~s2_q.sign & (s2_q.g | s2_q.s);
      RMM:     rnd_inc = s2_q.g;
      default: rnd_inc = s2_q.g & (s2_q.s | s2_q.man[0]);
    endcase
    man_sum   = {1'b0, s2_q.man} + {{MAN_W{1'b0}}, rnd_inc};
    s3_d      = '0;
    s3_d.vld  = s3_d_vld(s2_q.vld);
    s3_d.sign = s2_q.sign;
    s3_d.rm   = s2_q.rm;
    s3_d.sp   = s2_q.sp;
    s3_d.nv   = s2_q.nv;
    s3_d.nx   = s2_q.g | s2_q.s;
    // A carry out of 1.11..1 leaves the low mantissa bits at zero; only the exponent moves.
    s3_d.man  = man_sum[MAN_W-1:0];
    s3_d.e    = s2_q.e + (man_sum[MAN_W] ? ONE_E : '0);
  end

  function automatic logic s3_d_vld(input logic v);
    return v;
  endfunction

  logic ovf_inf;

  always_comb begin
    ovf_inf          = 1'b0;
    y_d              = {s3_q.sign, s3_q.e[EXP_W-1:0], s3_q.man};
    flags_d          = '0;
    flags_d[FLAG_NX] = s3_q.nx;
    if (!s3_q.e[EW-1] && (s3_q.e >= EMAX_E)) begin
      case (s3_q.rm)
        RTZ:     ovf_inf = 1'b0;
        RDN:     ovf_inf = s3_q.sign;
        RUP:     ovf_inf = ~s3_q.sign;
        default: ovf_inf = 1'b1;
      endcase
      y_d = ovf_inf ? {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                    : {s3_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      flags_d[FLAG_OF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end else if (s3_q.e[EW-1] || (s3_q.e == '0)) begin
      y_d              = {s3_q.sign, {(W-1){1'b0}}};
      flags_d[FLAG_UF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end
    case (s3_q.sp)
      SP_NAN: begin
        y_d              = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d          = '0;
        flags_d[FLAG_NV] = s3_q.nv;
      end
      SP_INF: begin
        y_d     = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d = '0;
      end
      SP_ZERO: begin
        y_d     = {s3_q.sign, {(W-1){1'b0}}};
        flags_d = '0;
      end
      default: ;
    endcase
    flags_d[FLAG_DZ] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      out_vld_q <= 1'b0;
      y_q       <= '0;
      flags_q   <= '0;
    end else if (!stall) begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      out_vld_q <= s3_q.vld;
      y_q       <= y_d;
      flags_q   <= flags_d;
    end
  end

endmodule

// File: tb/tb_f_mult_pipe.sv
// Directed bench for f_mult_pipe: binary32 vector table, half-precision spot checks,
// stall/stream ordering and asynchronous reset with ops in flight.
module tb_f_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic [2:0]  rounding;
  logic [4:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_y;
  logic [2:0]  h_rounding;
  logic [4:0]  h_flags;

  always #5 clk = ~clk;

  f_mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rounding(rounding), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .flags(flags)
  );

  f_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .rounding(h_rounding), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .y(h_y), .flags(h_flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] y;
    logic [4:0]  fl;
  } vec_t;

  localparam int NV = 32;
  vec_t        vt[NV];
  int          tests = 0;
  int          fails = 0;
  int          sidx[6] = '{0, 6, 7, 17, 18, 20};
  logic [31:0] ry[6];
  logic [4:0]  rf[6];
  int          got;
  int          extra;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp_v);
    end
  endtask

  // Starts #1 after a rising edge; op is accepted on the next edge and checked 3 edges later.
  task automatic run(input logic half, input int idx, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [2:0] irm, input logic [31:0] ey, input logic [4:0] ef);
    if (half) begin
      h_a = ia[15:0]; h_b = ib[15:0]; h_rounding = irm; h_in_valid = 1'b1;
    end else begin
      a = ia; b = ib; rounding = irm; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s%0d_valid_at_%0d", half ? "h" : "v", idx, k),
          32'(half ? h_out_valid : out_valid), (k == 3) ? 32'd1 : 32'd0);
    end
    chk($sformatf("%s%0d_y", half ? "h" : "v", idx), half ? {16'h0, h_y} : y, ey);
    chk($sformatf("%s%0d_flags", half ? "h" : "v", idx), 32'(half ? h_flags : flags), 32'(ef));
  endtask

  initial begin
    vt[0]  = '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000};
    vt[1]  = '{32'h00000000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'b10000};
    vt[2]  = '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000};
    vt[3]  = '{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101};
    vt[4]  = '{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101};
    vt[5]  = '{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'b00101};
    vt[6]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00001};
    vt[7]  = '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00001};
    vt[8]  = '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 5'b00001};
    vt[9]  = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011};
    vt[10] = '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000};
    vt[11] = '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'b00000};
    vt[12] = '{32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 5'b00000};
    vt[13] = '{32'h00000001, 32'h7F800000, 3'd0, 32'h7FC00000, 5'b10000};
    vt[14] = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 5'b00001};
    vt[15] = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 5'b00001};
    vt[16] = '{32'h3F800003, 32'h3FC00000, 3'd5, 32'h3FC00004, 5'b00001};
    vt[17] = '{32'h3FC00001, 32'h3FC00000, 3'd0, 32'h40100001, 5'b00001};
    vt[18] = '{32'hBFC00001, 32'h3FC00000, 3'd2, 32'hC0100001, 5'b00001};
    vt[19] = '{32'hBFC00001, 32'h3FC00000, 3'd3, 32'hC0100000, 5'b00001};
    vt[20] = '{32'h3FFFFFFE, 32'h3F800001, 3'd0, 32'h40000000, 5'b00001};
    vt[21] = '{32'h3FFFFFFE, 32'h3F800001, 3'd1, 32'h3FFFFFFF, 5'b00001};
    vt[22] = '{32'h7F7FFFFE, 32'h3F800001, 3'd0, 32'h7F800000, 5'b00101};
    vt[23] = '{32'h7F7FFFFE, 32'h3F800001, 3'd1, 32'h7F7FFFFF, 5'b00001};
    vt[24] = '{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b00101};
    vt[25] = '{32'h80800000, 32'h3F000000, 3'd0, 32'h80000000, 5'b00011};
    vt[26] = '{32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 5'b00000};
    vt[27] = '{32'h7F7FFFFF, 32'h40000000, 3'd4, 32'h7F800000, 5'b00101};
    vt[28] = '{32'h7F800000, 32'h7F800000, 3'd0, 32'h7F800000, 5'b00000};
    vt[29] = '{32'hFFC00000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'b00000};
    vt[30] = '{32'hFF800000, 32'h80000000, 3'd0, 32'h7FC00000, 5'b10000};
    vt[31] = '{32'h80000000, 32'h80000000, 3'd0, 32'h00000000, 5'b00000};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; rounding = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_rounding = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_h_out_valid", 32'(h_out_valid), 32'd0);
    chk("rst_h_in_ready", 32'(h_in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      run(1'b0, i, vt[i].a, vt[i].b, vt[i].rm, vt[i].y, vt[i].fl);

    run(1'b1, 0, 32'h3E00, 32'h4000, 3'd0, 32'h4200, 5'b00000);
    run(1'b1, 1, 32'h7BFF, 32'h4000, 3'd0, 32'h7C00, 5'b00101);
    run(1'b1, 2, 32'h3C01, 32'h3C01, 3'd0, 32'h3C02, 5'b00001);
    run(1'b1, 3, 32'h0400, 32'h3800, 3'd0, 32'h0000, 5'b00011);
    run(1'b1, 4, 32'h7C01, 32'h3C00, 3'd0, 32'h7E00, 5'b10000);

    // Stream of 6 back-to-back ops with a 4-cycle consumer stall after the first result.
    got = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          a = vt[sidx[k]].a; b = vt[sidx[k]].b; rounding = vt[sidx[k]].rm; in_valid = 1'b1;
          @(negedge clk);
          for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
          chk($sformatf("stream_drv%0d_ready", k), 32'(in_ready), 32'd1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 80 && got < 6; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            ry[got] = y;
            rf[got] = flags;
            got++;
            if (got == 1) begin
              @(posedge clk); #1;
              out_ready = 1'b0;
              for (int s = 0; s < 4; s++) begin
                @(negedge clk);
                chk($sformatf("stall%0d_in_ready", s), 32'(in_ready), 32'd0);
                chk($sformatf("stall%0d_out_valid", s), 32'(out_valid), 32'd1);
                chk($sformatf("stall%0d_y", s), y, vt[sidx[1]].y);
                chk($sformatf("stall%0d_flags", s), 32'(flags), 32'(vt[sidx[1]].fl));
              end
              @(posedge clk); #1;
              out_ready = 1'b1;
            end
          end
        end
      end
    join
    chk("stream_count", got, 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stream%0d_y", k), ry[k], vt[sidx[k]].y);
      chk($sformatf("stream%0d_flags", k), 32'(rf[k]), 32'(vt[sidx[k]].fl));
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream_no_extra", extra, 32'd0);

    // Asynchronous reset with the pipeline full.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      a = vt[k].a; b = vt[k].b; rounding = vt[k].rm; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_y", y, 32'd0);
    chk("async_rst_flags", 32'(flags), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("post_rst_no_stale", extra, 32'd0);
    @(posedge clk); #1;
    run(1'b0, 100, vt[17].a, vt[17].b, vt[17].rm, vt[17].y, vt[17].fl);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
